// File: rtl/lsu_bus_if.sv
// Load/store bus interface: accepts one core access at a time, checks alignment,
// runs the DAD/DDT/MREQ/ACKD_n handshake with timeout, and extends load data.
module lsu_bus_if #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n
);

  typedef enum logic [1:0] {IDLE, BUS, ERR} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Last counter value before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [BIT_WIDTH-1:0]   wdata_q;
  logic                   uns_q;
  logic                   misaligned;
  logic                   illegal;
  logic                   timeout_hit;

  function automatic logic [BIT_WIDTH-1:0] store_fmt(input logic [1:0] sz,
                                                     input logic [BIT_WIDTH-1:0] d);
    logic [BIT_WIDTH-1:0] r;
    r = d;
    if (sz == SZ_HALF) r = {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
    else if (sz == SZ_BYTE) r = {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
    return r;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] load_ext(input logic [1:0] sz,
                                                    input logic uns,
                                                    input logic [BIT_WIDTH-1:0] d);
    logic [BIT_WIDTH-1:0] r;
    r = d;
    if (sz == SZ_HALF) r = {{(BIT_WIDTH-16){~uns & d[15]}}, d[15:0]};
    else if (sz == SZ_BYTE) r = {{(BIT_WIDTH-8){~uns & d[7]}}, d[7:0]};
    return r;
  endfunction

  assign req_ready   = (state == IDLE);
  assign misaligned  = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign illegal     = (req_size == SZ_ILL);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // The data bus is driven only while a store cycle is on the bus.
  assign DDT = (MREQ && WRITE) ? wdata_q : {BIT_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= SZ_WORD;
      DAD        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      cnt        <= '0;
      wdata_q    <= '0;
      uns_q      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned || illegal) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state   <= BUS;
              DAD     <= req_addr;
              SIZE    <= req_size;
              WRITE   <= req_write;
              MREQ    <= 1'b1;
              cnt     <= '0;
              wdata_q <= store_fmt(req_size, req_wdata);
              uns_q   <= req_unsigned;
            end
          end
        end
        // Error response is already on the outputs; this cycle only blocks acceptance.
        ERR: state <= IDLE;
        BUS: begin
          if (!ACKD_n) begin
            state      <= IDLE;
            MREQ       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= WRITE ? '0 : load_ext(SIZE, uns_q, DDT);
          end else if (timeout_hit) begin
            state      <= IDLE;
            MREQ       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: driver issues accesses and plays the memory,
// monitor pops expected responses whenever resp_valid is seen.
module tb_lsu_bus_if;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] DAD;
  wire  [31:0] DDT;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;
  logic        mem_drive = 1'b0;
  logic [31:0] mem_data = '0;

  assign DDT = mem_drive ? mem_data : 32'bz;

  lsu_bus_if #(.BIT_WIDTH(32), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .DAD(DAD), .DDT(DDT), .MREQ(MREQ), .WRITE(WRITE),
    .SIZE(SIZE), .ACKD_n(ACKD_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   resp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension: take the low bytes, subtract 2^n when the sign bit is set.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd1) begin
      v = d % 32'h1_0000;
      if (!u && v >= 32'h8000) v = v - 32'h1_0000;
    end else if (sz == 2'd2) begin
      v = d % 32'h100;
      if (!u && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd1) return d % 32'h1_0000;
    if (sz == 2'd2) return d % 32'h100;
    return d;
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      exp_t e;
      resp_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
      end else begin
        e = q.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  // delay = number of bus edges with ACKD_n high before the ack edge
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] md, input int delay);
    exp_t e;
    int   cyc;
    int   n = 0;
    logic bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd0 && a % 4 != 0);
    if (bad) begin
      e.err = 1'b1; e.rdata = '0; cyc = 0;
    end else if (delay < TO) begin
      e.err = 1'b0; e.rdata = w ? 32'd0 : ref_load(sz, u, md); cyc = delay + 1;
    end else begin
      e.err = 1'b1; e.rdata = '0; cyc = TO;
    end
    wait_ready();
    q.push_back(e);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; mem_drive = !w; mem_data = md;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom; req_addr = $urandom; req_size = 2'($urandom);
    while (MREQ && n < 20) begin
      n++;
      check("DAD", DAD, a);
      check("SIZE", {30'b0, SIZE}, {30'b0, sz});
      check("WRITE", {31'b0, WRITE}, {31'b0, w});
      if (w) check("DDT_store", DDT, ref_store(sz, wd));
      ACKD_n = (n == delay + 1) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    check("mreq_cycles", n, cyc);
    ACKD_n = 1'($urandom);
    mem_drive = 1'b0;
  endtask

  initial begin
    int rc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_MREQ", {31'b0, MREQ}, 32'd0);
    check("rst_WRITE", {31'b0, WRITE}, 32'd0);
    check("rst_SIZE", {30'b0, SIZE}, 32'd0);
    check("rst_DAD", DAD, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    access(1'b0, 2'd0, 1'b0, 32'h8000_0010, 32'h0, 32'h1234_5678, 0);
    access(1'b0, 2'd2, 1'b0, 32'h8000_0003, 32'h0, 32'h0000_0080, 0);
    access(1'b0, 2'd2, 1'b1, 32'h8000_0003, 32'h0, 32'h0000_0080, 0);
    access(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h0000_8001, 1);
    access(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h0000_8001, 0);
    access(1'b1, 2'd2, 1'b0, 32'hF000_0000, 32'h1234_5641, 32'h0, 3);
    access(1'b0, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 0);
    access(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0);
    access(1'b0, 2'd0, 1'b0, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 10);
    access(1'b0, 2'd0, 1'b0, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 3);
    access(1'b1, 2'd1, 1'b0, 32'h8000_0041, 32'hFFFF_FFFF, 32'h0, 0);

    // Reset during the second bus cycle discards the access.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h8000_0100;
    ACKD_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_MREQ_before_rst", {31'b0, MREQ}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_MREQ", {31'b0, MREQ}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);

    // ACKD_n held low with no request must not produce a response.
    rc = resp_cnt;
    ACKD_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("idle_ack_no_resp", resp_cnt, rc);
    check("idle_ack_MREQ", {31'b0, MREQ}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = $urandom;
      if ($urandom % 4 != 0) a = (sz == 2'd0) ? a & ~32'h3 : (sz == 2'd1) ? a & ~32'h1 : a;
      access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, int'($urandom % 7));
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store bus interface between the core's memory stage and the external data-memory port (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one access at a time from the core and checks alignment.
- Runs the bus handshake with unbounded wait states and a timeout.
- Returns load data zero- or sign-extended to 32 bits.

Parameters:
- BIT_WIDTH, 32, data/address width.
- TIMEOUT, 16, max bus cycles waiting for ACKD_n before error; 0 disables the timeout.
- CNT_WIDTH, 8, width of the wait-state counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  core access request
- req_ready  out  1  block can accept a request; high only in IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=word, 01=half, 10=byte, 11=illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or timeout
- DAD  out  32  bus address
- DDT  inout  32  bus data; driven only during a store cycle, otherwise high-Z
- MREQ  out  1  bus request
- WRITE  out  1  bus direction
- SIZE  out  2  bus size, same encoding as req_size
- ACKD_n  in  1  bus acknowledge, active-low

Behaviour:
- Reset values (on the rising edge with rst=1):
  - State IDLE; MREQ, WRITE, resp_valid, resp_err = 0.
  - SIZE=00, DAD=0, resp_rdata=0, wait counter=0, DDT high-Z.
  - req_ready=1 from the first cycle after reset.
- States: IDLE, BUS, ERR.
- IDLE, acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - Misaligned when size=01 && addr[0], or size=00 && addr[1:0]!=0; size=11 is illegal.
  - Misaligned or illegal → ERR. No bus cycle is started.
  - Otherwise → BUS. DAD/SIZE/WRITE are registered from the request; MREQ=1; counter cleared.
  - Store data is registered as: word = wdata; half = {16'b0, wdata[15:0]}; byte = {24'b0, wdata[7:0]}.
- ERR: lasts one cycle. resp_valid=1, resp_err=1, resp_rdata=0, then → IDLE.
- BUS, per edge:
  - DAD, SIZE, WRITE and DDT are held stable for the whole cycle.
  - ACKD_n=0 → transaction completes. MREQ=0 and resp_valid=1 next cycle, → IDLE.
    - Load: DDT is captured at that edge and extended from bit 31/15/7 according to size and req_unsigned.
    - Store: resp_rdata=0.
  - ACKD_n=1 and TIMEOUT!=0 and counter==TIMEOUT-1 → MREQ=0; resp_valid=1, resp_err=1, resp_rdata=0; → IDLE.
  - Otherwise the counter increments.
- Ack and timeout on the same edge: the ack wins.
- ACKD_n is ignored whenever MREQ=0; the memory side may hold it low permanently.
- Minimum latency: an accepted request with an immediate ack has MREQ high for exactly 1 cycle; resp_valid follows on the next cycle.
- Throughput: one new request per 2 cycles. A request may be accepted in the same cycle resp_valid is high.
- resp_valid is a single-cycle pulse. resp_rdata and resp_err hold their values until the next response.
- Reset mid-BUS: MREQ drops on that edge, DDT goes high-Z, no resp_valid is emitted, and the in-flight access is discarded.
- Addresses are passed through unmodified. STDOUT and EXIT addresses get no special handling.

Test Plan:
1. Load word at 0x8000_0010, ACKD_n=0 at the first edge, DDT=0x1234_5678 → MREQ high 1 cycle; DAD=0x8000_0010, SIZE=00, WRITE=0; resp_rdata=0x1234_5678, resp_err=0.
2. Sub-word loads:
   - lb at 0x8000_0003 with DDT=0x0000_0080 → 0xFFFF_FF80.
   - lbu at the same address → 0x0000_0080.
   - lh at 0x8000_0002 with DDT=0x0000_8001 → 0xFFFF_8001.
   - lhu at the same address → 0x0000_8001.
3. sb to 0xF000_0000 with wdata=0x1234_5641, ack delayed 3 cycles → DDT=0x0000_0041, SIZE=10, WRITE=1, all stable for 4 MREQ cycles; resp_valid the cycle after the ack; DDT high-Z afterwards.
4. lw at 0x8000_0002, and separately size=11 → MREQ never asserted; resp_valid next cycle with resp_err=1, resp_rdata=0.
5. Timeout with TIMEOUT=4:
   - ACKD_n held high → MREQ high exactly 4 cycles, then resp_err=1.
   - Repeat with ACKD_n=0 on the 4th edge → success, resp_err=0.
6. Reset and ignored ack:
   - rst=1 during the 2nd BUS cycle → MREQ=0 after that edge, no resp_valid, req_ready=1.
   - ACKD_n held low with no request → no response generated.
